// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
// Redirect outputs are combinational; everything headed to the memory stage is registered.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [4:0]      RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a, write_data_e, src_b, alu_result_e;
  logic            zero_e;

  // Select 11 is reserved and falls back to the register-file operand.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUResultM;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data_e;

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result_e = src_a + src_b;
      3'b001:  alu_result_e = src_a - src_b;
      3'b010:  alu_result_e = src_a & src_b;
      3'b011:  alu_result_e = src_a | src_b;
      3'b101:  alu_result_e = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result_e = '0;
    endcase
  end

  assign zero_e    = (alu_result_e == '0);
  assign PCSrcE    = (BranchE & zero_e) | JumpE;
  assign PCTargetE = PCE + ImmExtE;

  // Forwarded B is stored as store data so a forwarded store writes the fresh value.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      RdM        <= 5'd0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= alu_result_e;
      WriteDataM <= write_data_e;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule
